nes_oam_dma: RTL and testbench
==============================

Name: nes_oam_dma

Overview:
- Sprite-DMA controller ($4014) between the 6502 CPU core and the CPU-side memory bus.
- A CPU write to the DMA register stalls the CPU through rdy and takes ownership of the bus.
- It then copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port ($2004) in alternating read/write CPU cycles, and returns the bus to the CPU when done.
- Outside a DMA transfer it passes the CPU bus through unchanged.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers a DMA; the written byte is the source page.
OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
XFER_LEN, 256, bytes per transfer; power of two, at most 256.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cyc_en  in  1  one-clk strobe marking a CPU bus cycle (CPU syn_clk); all state advances only when cyc_en=1
cpu_addr  in  16  CPU address_out
cpu_dout  in  8  CPU data_out
cpu_ren  in  1  CPU read enable
cpu_wen  in  1  CPU write enable
cpu_rdy  out  1  to CPU rdy; 0 stalls the CPU
bus_addr  out  16  muxed bus address
bus_dout  out  8  muxed bus write data
bus_ren  out  1  muxed bus read enable
bus_wen  out  1  muxed bus write enable
bus_din  in  8  read data returned by the bus (valid in the same cycle as bus_ren)
dma_active  out  1  1 while DMA owns the bus

Behaviour:
- Reset (async, rst=1): state=IDLE, cpu_rdy=1, dma_active=0, page=0, count=0, buffer=0, parity=0. Bus outputs follow the IDLE passthrough.
- parity register: toggles on every cyc_en. A cycle is "even" when parity=0 at its start.
- IDLE:
  - bus_* = cpu_* combinationally.
  - A trigger is cyc_en & cpu_wen & cpu_addr==DMA_REG_ADDR.
  - On a trigger: page<=cpu_dout, count<=0, next state HALT. The trigger write itself still passes to the bus.
- HALT (one CPU cycle):
  - cpu_rdy=0, dma_active=1, bus_ren=0, bus_wen=0.
  - At its cyc_en: go to READ if the next cycle is even, otherwise go to ALIGN.
- ALIGN (one CPU cycle): same outputs as HALT, then go to READ.
- READ:
  - Drives bus_addr={page,count[7:0]}, bus_ren=1, bus_wen=0.
  - At cyc_en: buffer<=bus_din, go to WRITE.
- WRITE:
  - Drives bus_addr=OAM_DATA_ADDR, bus_dout=buffer, bus_wen=1, bus_ren=0.
  - At cyc_en: if count==XFER_LEN-1, go to IDLE; else count<=count+1 and go to READ.
- cpu_rdy and dma_active are registered.
  - cpu_rdy=0 and dma_active=1 from the clk after the trigger's cyc_en until the clk after the final WRITE's cyc_en.
  - Both are 1/0 respectively in IDLE.
- In every non-IDLE state the CPU's bus outputs are ignored. Triggers during DMA are ignored; they cannot restart or alter page.
- While cyc_en=0 all registers hold and outputs are stable.
- Total stall: 513 CPU cycles if the trigger cycle is even, 514 if odd (HALT + optional ALIGN + 2*XFER_LEN).
- The source address never crosses a page: count wraps within 8 bits; page=FF reads $FF00-$FFFF.
- rst asserted mid-transfer aborts immediately to IDLE with cpu_rdy=1. Bytes already written stay written.

Test Plan:
- Passthrough: rst release, CPU reads $8000 and writes $0300=5A. Required: bus_* mirrors cpu_* each cycle, cpu_rdy=1, dma_active=0.
- Even-cycle trigger: fill $0200-$02FF with byte=index, write $4014=02 on an even cycle. Required:
  - cpu_rdy low for exactly 513 cyc_en.
  - 256 reads of $0200..$02FF, each followed by a write to $2004 with the same byte (00..FF in order).
- Odd-cycle trigger: same as above but the trigger is on an odd cycle. Required: one ALIGN cycle with no bus access, 514-cycle stall, identical data sequence.
- Retrigger during DMA: write $4014=03 while busy. Required: ignored; the transfer completes from page 02 and there is no second DMA.
- Mid-transfer reset: assert rst after 100 writes. Required: immediate IDLE, cpu_rdy=1, bus passthrough. A new $4014=07 trigger then starts a full transfer from $0700.
- cyc_en gaps: random 0-3 idle clks between cyc_en pulses. Required: the same access sequence and cycle count as the even-cycle trigger test, with outputs stable during the gaps.

Source files
------------

// File: rtl/nes_oam_dma_if.sv
// nes_oam_dma_if: CPU-side and memory-side bus bundle for the sprite DMA.
// master = DMA controller, slave = CPU core plus memory bus around it.
interface nes_oam_dma_if;
  logic        cyc_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_ren;
  logic        cpu_wen;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_ren;
  logic        bus_wen;
  logic [7:0]  bus_din;
  logic        dma_active;

  modport master (
    input  cyc_en,
    input  cpu_addr,
    input  cpu_dout,
    input  cpu_ren,
    input  cpu_wen,
    input  bus_din,
    output cpu_rdy,
    output bus_addr,
    output bus_dout,
    output bus_ren,
    output bus_wen,
    output dma_active
  );

  modport slave (
    output cyc_en,
    output cpu_addr,
    output cpu_dout,
    output cpu_ren,
    output cpu_wen,
    output bus_din,
    input  cpu_rdy,
    input  bus_addr,
    input  bus_dout,
    input  bus_ren,
    input  bus_wen,
    input  dma_active
  );
endinterface

// File: rtl/nes_oam_dma.sv
// nes_oam_dma: $4014 sprite DMA, copies one CPU page into OAM ($2004).
// Stalls the CPU via rdy and owns the bus for 513/514 CPU cycles.
module nes_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input logic clk,
  input logic rst,
  nes_oam_dma_if.master dma
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

  logic [2:0] state;
  logic [7:0] page;
  logic [7:0] count;
  logic [7:0] buffer;
  logic       parity;
  logic       rdy_q;
  logic       act_q;
  logic       trig;

  assign trig = dma.cyc_en & dma.cpu_wen &
                (dma.cpu_addr == DMA_REG_ADDR);

  // FSM, transfer counters and registered rdy/active; advance on cyc_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      page   <= 8'h00;
      count  <= 8'h00;
      buffer <= 8'h00;
      parity <= 1'b0;
      rdy_q  <= 1'b1;
      act_q  <= 1'b0;
    end else if (dma.cyc_en) begin
      parity <= ~parity;
      case (state)
        S_IDLE: begin
          if (trig) begin
            page  <= dma.cpu_dout;
            count <= 8'h00;
            state <= S_HALT;
            rdy_q <= 1'b0;
            act_q <= 1'b1;
          end
        end
        // odd halt cycle means the next one is even: read right away
        S_HALT:  state <= parity ? S_READ : S_ALIGN;
        S_ALIGN: state <= S_READ;
        S_READ: begin
          buffer <= dma.bus_din;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          if (count == LAST) begin
            state <= S_IDLE;
            rdy_q <= 1'b1;
            act_q <= 1'b0;
          end else begin
            count <= count + 8'd1;
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // bus mux: CPU passthrough in IDLE, DMA-driven otherwise
  always_comb begin
    dma.bus_addr = dma.cpu_addr;
    dma.bus_dout = dma.cpu_dout;
    dma.bus_ren  = dma.cpu_ren;
    dma.bus_wen  = dma.cpu_wen;
    case (state)
      S_HALT, S_ALIGN: begin
        dma.bus_addr = {page, count};
        dma.bus_dout = buffer;
        dma.bus_ren  = 1'b0;
        dma.bus_wen  = 1'b0;
      end
      S_READ: begin
        dma.bus_addr = {page, count};
        dma.bus_dout = buffer;
        dma.bus_ren  = 1'b1;
        dma.bus_wen  = 1'b0;
      end
      S_WRITE: begin
        dma.bus_addr = OAM_DATA_ADDR;
        dma.bus_dout = buffer;
        dma.bus_ren  = 1'b0;
        dma.bus_wen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign dma.cpu_rdy    = rdy_q;
  assign dma.dma_active = act_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// tb_nes_oam_dma: directed tests for the $4014 sprite DMA.
// Memory model returns a per-page pattern; accesses are logged per cycle.
module tb_nes_oam_dma;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nes_oam_dma_if bif();

  nes_oam_dma dut (
    .clk (clk),
    .rst (rst),
    .dma (bif)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] rd_q[$];
  logic [23:0] wr_q[$];
  int stall_cnt, idle_cnt, gap_err, act_err;
  bit tb_par, timed_out, prev_gap;
  logic [27:0] last_o;

  function automatic logic [7:0] ev(logic [15:0] a);
    case (a[15:8])
      8'h07:   return ~a[7:0];
      8'hFF:   return a[7:0] ^ 8'h5A;
      default: return a[7:0];
    endcase
  endfunction

  always_comb bif.bus_din = ev(bif.bus_addr);

  task automatic step(input bit en, input bit ren, input bit wen,
                      input logic [15:0] a, input logic [7:0] d);
    logic [27:0] o;
    @(negedge clk);
    bif.cyc_en   = en;
    bif.cpu_ren  = ren;
    bif.cpu_wen  = wen;
    bif.cpu_addr = a;
    bif.cpu_dout = d;
    #1;
    o = {bif.bus_addr, bif.bus_dout, bif.bus_ren,
         bif.bus_wen, bif.cpu_rdy, bif.dma_active};
    if (en) begin
      if (!bif.cpu_rdy) stall_cnt++;
      if (!bif.cpu_rdy && !bif.bus_ren && !bif.bus_wen) idle_cnt++;
      if (bif.bus_ren) rd_q.push_back(bif.bus_addr);
      if (bif.bus_wen) wr_q.push_back({bif.bus_addr, bif.bus_dout});
      if (bif.dma_active === bif.cpu_rdy) act_err++;
      tb_par = ~tb_par;
    end else if (prev_gap && o !== last_o) begin
      gap_err++;
    end
    prev_gap = !en;
    last_o = o;
  endtask

  task automatic run_dma(input logic [7:0] page, input bit odd,
                         input int gapmax, input int retrig_at,
                         input int abort_n);
    int n;
    bit done;
    if (tb_par != odd) step(1, 0, 0, 16'h0000, 8'h00);
    step(1, 0, 1, 16'h4014, page);
    rd_q.delete();
    wr_q.delete();
    stall_cnt = 0;
    idle_cnt = 0;
    gap_err = 0;
    act_err = 0;
    timed_out = 0;
    done = 0;
    n = 0;
    while (!done) begin
      repeat ($urandom_range(0, gapmax)) step(0, 0, 0, 16'h0000, 8'h00);
      if (n == retrig_at) step(1, 0, 1, 16'h4014, 8'h03);
      else step(1, 0, 0, 16'h0000, 8'h00);
      n++;
      if (bif.cpu_rdy) done = 1;
      else if (abort_n > 0 && wr_q.size() == abort_n) done = 1;
      else if (n > 2000) begin
        timed_out = 1;
        done = 1;
      end
    end
  endtask

  function automatic int seq_err(logic [7:0] page);
    int e = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] ea;
      ea = {page, 8'(i)};
      if (i >= rd_q.size() || rd_q[i] !== ea) e++;
      if (i >= wr_q.size() || wr_q[i] !== {16'h2004, ev(ea)}) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    bif.cpu_addr = 16'hABCD;
    bif.cpu_ren = 1'b1;
    #1;
    checks++;
    if (bif.cpu_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy got=%b exp=1", bif.cpu_rdy);
    end
    checks++;
    if (bif.dma_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_active got=%b exp=0", bif.dma_active);
    end
    checks++;
    if (bif.bus_addr !== 16'hABCD || bif.bus_ren !== 1'b1) begin
      failures++;
      $display("FAIL reset_pass got=%h/%b exp=abcd/1",
               bif.bus_addr, bif.bus_ren);
    end
    @(negedge clk);
    rst = 1'b0;
    tb_par = 0;
  endtask

  task automatic test_passthrough();
    step(1, 1, 0, 16'h8000, 8'h00);
    checks++;
    if ({bif.bus_addr, bif.bus_ren, bif.bus_wen} !== {16'h8000, 2'b10}) begin
      failures++;
      $display("FAIL pass_read got=%h %b%b exp=8000 10",
               bif.bus_addr, bif.bus_ren, bif.bus_wen);
    end
    step(1, 0, 1, 16'h0300, 8'h5A);
    checks++;
    if ({bif.bus_addr, bif.bus_dout, bif.bus_ren, bif.bus_wen} !==
        {16'h0300, 8'h5A, 2'b01}) begin
      failures++;
      $display("FAIL pass_write got=%h %h %b%b exp=0300 5a 01",
               bif.bus_addr, bif.bus_dout, bif.bus_ren, bif.bus_wen);
    end
    checks++;
    if (bif.cpu_rdy !== 1'b1 || bif.dma_active !== 1'b0) begin
      failures++;
      $display("FAIL pass_status got=%b%b exp=10",
               bif.cpu_rdy, bif.dma_active);
    end
  endtask

  task automatic test_even();
    run_dma(8'h02, 0, 0, -1, 0);
    checks++;
    if (stall_cnt !== 513 || timed_out) begin
      failures++;
      $display("FAIL even_stall got=%0d exp=513", stall_cnt);
    end
    checks++;
    if (idle_cnt !== 1) begin
      failures++;
      $display("FAIL even_idle got=%0d exp=1", idle_cnt);
    end
    checks++;
    if (seq_err(8'h02) !== 0) begin
      failures++;
      $display("FAIL even_seq got=%0d errs rd=%0d wr=%0d exp=0 256 256",
               seq_err(8'h02), rd_q.size(), wr_q.size());
    end
    checks++;
    if (act_err !== 0) begin
      failures++;
      $display("FAIL even_active got=%0d exp=0", act_err);
    end
  endtask

  task automatic test_odd();
    run_dma(8'h02, 1, 0, -1, 0);
    checks++;
    if (stall_cnt !== 514 || timed_out) begin
      failures++;
      $display("FAIL odd_stall got=%0d exp=514", stall_cnt);
    end
    checks++;
    if (idle_cnt !== 2) begin
      failures++;
      $display("FAIL odd_idle got=%0d exp=2", idle_cnt);
    end
    checks++;
    if (seq_err(8'h02) !== 0) begin
      failures++;
      $display("FAIL odd_seq got=%0d exp=0", seq_err(8'h02));
    end
  endtask

  task automatic test_retrigger();
    run_dma(8'h02, 0, 0, 50, 0);
    checks++;
    if (stall_cnt !== 513 || timed_out) begin
      failures++;
      $display("FAIL retrig_stall got=%0d exp=513", stall_cnt);
    end
    checks++;
    if (seq_err(8'h02) !== 0) begin
      failures++;
      $display("FAIL retrig_seq got=%0d exp=0", seq_err(8'h02));
    end
    repeat (20) step(1, 0, 0, 16'h0000, 8'h00);
    checks++;
    if (stall_cnt !== 513 || rd_q.size() !== 256) begin
      failures++;
      $display("FAIL retrig_second got=%0d/%0d exp=513/256",
               stall_cnt, rd_q.size());
    end
  endtask

  task automatic test_page_ff();
    run_dma(8'hFF, 1, 0, -1, 0);
    checks++;
    if (stall_cnt !== 514 || timed_out) begin
      failures++;
      $display("FAIL pageff_stall got=%0d exp=514", stall_cnt);
    end
    checks++;
    if (seq_err(8'hFF) !== 0) begin
      failures++;
      $display("FAIL pageff_seq got=%0d exp=0", seq_err(8'hFF));
    end
  endtask

  task automatic test_mid_reset();
    run_dma(8'h02, 0, 0, -1, 100);
    checks++;
    if (wr_q.size() !== 100 || bif.cpu_rdy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre got=%0d/%b exp=100/0",
               wr_q.size(), bif.cpu_rdy);
    end
    @(negedge clk);
    bif.cyc_en = 1'b0;
    bif.cpu_ren = 1'b1;
    bif.cpu_wen = 1'b0;
    bif.cpu_addr = 16'h1234;
    rst = 1'b1;
    #1;
    checks++;
    if (bif.cpu_rdy !== 1'b1 || bif.dma_active !== 1'b0) begin
      failures++;
      $display("FAIL midrst_status got=%b%b exp=10",
               bif.cpu_rdy, bif.dma_active);
    end
    checks++;
    if ({bif.bus_addr, bif.bus_ren, bif.bus_wen} !== {16'h1234, 2'b10}) begin
      failures++;
      $display("FAIL midrst_pass got=%h %b%b exp=1234 10",
               bif.bus_addr, bif.bus_ren, bif.bus_wen);
    end
    @(negedge clk);
    rst = 1'b0;
    tb_par = 0;
    prev_gap = 0;
    run_dma(8'h07, 0, 0, -1, 0);
    checks++;
    if (stall_cnt !== 513 || timed_out) begin
      failures++;
      $display("FAIL midrst_restall got=%0d exp=513", stall_cnt);
    end
    checks++;
    if (seq_err(8'h07) !== 0) begin
      failures++;
      $display("FAIL midrst_seq got=%0d exp=0", seq_err(8'h07));
    end
  endtask

  task automatic test_gaps();
    run_dma(8'h02, 0, 3, -1, 0);
    checks++;
    if (stall_cnt !== 513 || timed_out) begin
      failures++;
      $display("FAIL gaps_stall got=%0d exp=513", stall_cnt);
    end
    checks++;
    if (seq_err(8'h02) !== 0) begin
      failures++;
      $display("FAIL gaps_seq got=%0d exp=0", seq_err(8'h02));
    end
    checks++;
    if (gap_err !== 0) begin
      failures++;
      $display("FAIL gaps_stable got=%0d exp=0", gap_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    bif.cyc_en = 1'b0;
    bif.cpu_addr = 16'h0000;
    bif.cpu_dout = 8'h00;
    bif.cpu_ren = 1'b0;
    bif.cpu_wen = 1'b0;
    tb_par = 0;
    prev_gap = 0;
    last_o = '0;
    stall_cnt = 0;
    idle_cnt = 0;
    gap_err = 0;
    act_err = 0;
    timed_out = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_passthrough();
    test_even();
    test_odd();
    test_retrigger();
    test_page_ff();
    test_mid_reset();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
